// File: rtl/data_mem_responder_if.sv
// Handshake bundle between the processor's data-memory port and data_mem_responder.
// The master drives requests and the slave returns status and load data.
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        ready;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        busy;
  logic        error;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  ready, resp_valid, read_data, busy, error
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output ready, resp_valid, read_data, busy, error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per load or store.
// Define DMEM_ERR_EN to add misaligned, out-of-range and read/write-conflict error reporting.
//
// state  | meaning
// S_IDLE | ready for a request; accepts MemRead/MemWrite on this edge
// S_WAIT | wait states; counter runs down to 1
// S_DONE | completion cycle; RespValid high, store commits at the closing edge
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
  end
  if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("data_mem_responder: DEPTH must be a power of 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      read_data_q;
  logic [31:0]      load_val;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_wr;
  logic             load_now;

  assign accept = bus.ready && (bus.mem_read || bus.mem_write);

  // The op fields are taken straight from the bus on the accept edge, so a
  // zero-wait load can fetch its data on the same edge it is accepted.
  assign cur_idx  = (state == S_IDLE) ? bus.address[IDX_W+1:2] : idx_q;
  assign cur_wr   = (state == S_IDLE) ? bus.mem_write : wr_q;
  assign load_now = (state != S_DONE) && (state_nxt == S_DONE) && !cur_wr;

`ifdef DMEM_ERR_EN
  logic addr_bad_q, both_q, cur_bad, in_bad;

  assign in_bad  = (|bus.address[1:0]) || (|bus.address[31:IDX_W+2]);
  assign cur_bad = (state == S_IDLE) ? in_bad : addr_bad_q;
  assign load_val = cur_bad ? 32'hDEAD_BEEF : mem[cur_idx];
`else
  assign load_val = mem[cur_idx];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      read_data_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= WAIT_INIT;
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
      if (load_now)
        read_data_q <= load_val;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = (WAIT_INIT == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready      = (state == S_IDLE) && !reset;
    bus.busy       = (state == S_WAIT) || (state == S_DONE);
    bus.resp_valid = (state == S_DONE);
    bus.read_data  = read_data_q;
`ifdef DMEM_ERR_EN
    bus.error      = (state == S_DONE) && (addr_bad_q || both_q);
`else
    bus.error      = 1'b0;
`endif
  end

  // Request capture; both strobes high is a store
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.mem_write;
      idx_q   <= bus.address[IDX_W+1:2];
      wdata_q <= bus.write_data;
`ifdef DMEM_ERR_EN
      addr_bad_q <= in_bad;
      both_q     <= bus.mem_read && bus.mem_write;
`endif
    end
  end

  // Storage is deliberately not reset; a reset during DONE drops the store
  always_ff @(posedge clk) begin
`ifdef DMEM_ERR_EN
    if (!reset && state == S_DONE && wr_q && !addr_bad_q)
`else
    if (!reset && state == S_DONE && wr_q)
`endif
      mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: table of load/store vectors on a 2-wait-state instance, plus
// hand sequences for reset during WAIT and a zero-wait instance.
module tb_data_mem_responder;
`ifdef DMEM_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        err_flag;
  } vec_t;

  localparam int NV = 13;
  vec_t v [NV];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request on bus_a and returns when RespValid is seen (or the budget runs out)
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic busy1, output logic rdy_done);
    @(negedge clk);
    check({tag, " ready_at_req"}, {31'd0, bus_a.ready}, 32'd1);
    bus_a.mem_read   = rd;
    bus_a.mem_write  = wr;
    bus_a.address    = addr;
    bus_a.write_data = wdata;
    @(negedge clk);
    lat   = 1;
    busy1 = bus_a.busy;
    bus_a.mem_read   = 1'b0;
    bus_a.mem_write  = 1'b0;
    bus_a.address    = 32'hFFFF_FFFF;
    bus_a.write_data = 32'h0;
    while (!bus_a.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata    = bus_a.read_data;
    err      = bus_a.error;
    rdy_done = bus_a.ready;
  endtask

  logic [31:0] rdata;
  logic        err, busy1, rdy_done, seen_resp;
  int          lat;

  initial begin
    v[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
    v[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
    v[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
    v[3]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0};
    v[4]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hAAAA_5555, 32'hCAFE_F00D, 1'b0};
    v[5]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hAAAA_5555, 1'b0};
    v[6]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'hAAAA_5555, 1'b0};
    v[7]  = '{1'b0, 1'b1, 32'h0000_1008, 32'hA5A5_A5A5, 32'hAAAA_5555, 1'b1};
    v[8]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,
              ERR_ON ? 32'h1111_1111 : 32'hA5A5_A5A5, 1'b0};
    v[9]  = '{1'b1, 1'b1, 32'h0000_0030, 32'h0000_0007,
              ERR_ON ? 32'h1111_1111 : 32'hA5A5_A5A5, 1'b1};
    v[10] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         32'h0000_0007, 1'b0};
    v[11] = '{1'b1, 1'b0, 32'h0000_0031, 32'h0,
              ERR_ON ? 32'hDEAD_BEEF : 32'h0000_0007, 1'b1};
    v[12] = '{1'b1, 1'b0, 32'h0000_1010, 32'h0,
              ERR_ON ? 32'hDEAD_BEEF : 32'h1234_5678, 1'b1};

    bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.address = '0; bus_a.write_data = '0;
    bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.address = '0; bus_b.write_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst ready",      {31'd0, bus_a.ready},      32'd1);
    check("rst busy",       {31'd0, bus_a.busy},       32'd0);
    check("rst resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    check("rst read_data",  bus_a.read_data,           32'd0);
    check("rst error",      {31'd0, bus_a.error},      32'd0);

    for (int i = 0; i < NV; i++) begin
      do_op(v[i].rd, v[i].wr, v[i].addr, v[i].wdata, $sformatf("vec%0d", i),
            rdata, err, lat, busy1, rdy_done);
      check($sformatf("vec%0d latency", i),   lat,                32'd3);
      check($sformatf("vec%0d busy", i),      {31'd0, busy1},     32'd1);
      check($sformatf("vec%0d ready_done", i), {31'd0, rdy_done}, 32'd0);
      check($sformatf("vec%0d read_data", i), rdata,              v[i].exp_rdata);
      check($sformatf("vec%0d error", i),     {31'd0, err},       {31'd0, ERR_ON & v[i].err_flag});
      @(negedge clk);
      check($sformatf("vec%0d ready_back", i), {31'd0, bus_a.ready}, 32'd1);
      check($sformatf("vec%0d pulse_end", i),  {31'd0, bus_a.resp_valid}, 32'd0);
    end

    // Reset while a store sits in WAIT: the store must be dropped
    do_op(1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, "pre20", rdata, err, lat, busy1, rdy_done);
    @(negedge clk);
    bus_a.mem_write = 1'b1; bus_a.address = 32'h20; bus_a.write_data = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_a.mem_write = 1'b0; bus_a.address = 32'h0;
    check("abort busy_in_wait", {31'd0, bus_a.busy}, 32'd1);
    reset = 1'b1;
    seen_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen_resp = seen_resp | bus_a.resp_valid;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_resp = seen_resp | bus_a.resp_valid;
    end
    check("abort no_resp",   {31'd0, seen_resp},   32'd0);
    check("abort ready",     {31'd0, bus_a.ready}, 32'd1);
    check("abort read_data", bus_a.read_data,      32'd0);
    do_op(1'b1, 1'b0, 32'h20, 32'h0, "post20", rdata, err, lat, busy1, rdy_done);
    check("abort old_value", rdata, 32'h0BAD_F00D);
    check("abort latency",   lat,   32'd3);

    // Zero-wait instance: completion on the cycle after accept
    @(negedge clk);
    check("w0 ready_idle", {31'd0, bus_b.ready}, 32'd1);
    bus_b.mem_write = 1'b1; bus_b.address = 32'h4; bus_b.write_data = 32'h55AA_0001;
    @(negedge clk);
    bus_b.mem_write = 1'b0;
    check("w0 st resp_valid", {31'd0, bus_b.resp_valid}, 32'd1);
    check("w0 st ready",      {31'd0, bus_b.ready},      32'd0);
    check("w0 st busy",       {31'd0, bus_b.busy},       32'd1);
    @(negedge clk);
    check("w0 st ready_back", {31'd0, bus_b.ready},      32'd1);
    check("w0 st pulse_end",  {31'd0, bus_b.resp_valid}, 32'd0);
    bus_b.mem_read = 1'b1;
    @(negedge clk);
    bus_b.mem_read = 1'b0;
    check("w0 ld resp_valid", {31'd0, bus_b.resp_valid}, 32'd1);
    check("w0 ld read_data",  bus_b.read_data,           32'h55AA_0001);
    check("w0 ld ready",      {31'd0, bus_b.ready},      32'd0);
    @(negedge clk);
    check("w0 ld ready_back", {31'd0, bus_b.ready},      32'd1);
    check("w0 ld held",       bus_b.read_data,           32'h55AA_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
